// File: rtl/bicubic_phase_gen.sv
// Horizontal source-position generator for the bicubic scaler: walks a Q4.16 step
// across one output line and emits tap index, blend fraction and tap-window advance.
module bicubic_phase_gen #(
   parameter int FRAC_W = 8,
   parameter int DIM_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DIM_W-1:0]  src_len,
   input  logic [DIM_W-1:0]  dst_len,
   input  logic [19:0]       step,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIM_W-1:0]  src_idx,
   output logic [FRAC_W:0]   x_blend,
   output logic [4:0]        src_adv,
   output logic [FRAC_W:0]   coeff_one,
   output logic [FRAC_W:0]   coeff_half,
   output logic              done
);
   localparam int ACC_W = DIM_W + 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [DIM_W-1:0] src_len_q, src_len_d;
   logic [DIM_W-1:0] dst_len_q, dst_len_d;
   logic [DIM_W-1:0] cnt_q, cnt_d;
   logic [19:0]      step_q, step_d;
   logic [ACC_W-1:0] acc_q, acc_d, acc_next;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic [DIM_W-1:0] src_idx_q, src_idx_d;
   logic [FRAC_W:0]  x_blend_q, x_blend_d;
   logic [4:0]       src_adv_q, src_adv_d;
   logic [FRAC_W:0]  coeff_one_q, coeff_one_d;
   logic [FRAC_W:0]  coeff_half_q, coeff_half_d;

   logic [DIM_W-1:0] int_part, last_idx, next_idx;
   logic [FRAC_W:0]  next_blend;
   logic             clamp;

   // Phase of the next output pixel; blend is meaningless past the last tap.
   always_comb begin
      acc_next   = acc_q + ACC_W'(step_q);
      int_part   = acc_next[ACC_W-1:16];
      last_idx   = src_len_q - DIM_W'(1);
      clamp      = int_part > last_idx;
      next_idx   = clamp ? last_idx : int_part;
      next_blend = clamp ? '0 : {1'b0, acc_next[15 -: FRAC_W]};
   end

   always_comb begin
      state_d      = state_q;
      src_len_d    = src_len_q;
      dst_len_d    = dst_len_q;
      step_d       = step_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      done_d       = 1'b0;
      src_idx_d    = src_idx_q;
      x_blend_d    = x_blend_q;
      src_adv_d    = src_adv_q;
      coeff_one_d  = {1'b1, {FRAC_W{1'b0}}};
      coeff_half_d = {2'b01, {(FRAC_W-1){1'b0}}};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_len_d = src_len;
               dst_len_d = dst_len;
               step_d    = step;
               acc_d     = '0;
               cnt_d     = '0;
               if (dst_len != '0) begin
                  state_d     = RUN;
                  out_valid_d = 1'b1;
                  src_idx_d   = '0;
                  x_blend_d   = '0;
                  src_adv_d   = '0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (out_ready) begin
               acc_d = acc_next;
               cnt_d = cnt_q + DIM_W'(1);
               if (cnt_q == dst_len_q - DIM_W'(1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  src_idx_d = next_idx;
                  x_blend_d = next_blend;
                  src_adv_d = 5'(next_idx - src_idx_q);
               end
            end
         end
         // An empty line enters DONE without the pulse and raises it one cycle later.
         DONE: begin
            done_d  = ~done_q;
            state_d = done_q ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_len_q    <= '0;
         dst_len_q    <= '0;
         step_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         src_idx_q    <= '0;
         x_blend_q    <= '0;
         src_adv_q    <= '0;
         coeff_one_q  <= '0;
         coeff_half_q <= '0;
      end else begin
         state_q      <= state_d;
         src_len_q    <= src_len_d;
         dst_len_q    <= dst_len_d;
         step_q       <= step_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         done_q       <= done_d;
         src_idx_q    <= src_idx_d;
         x_blend_q    <= x_blend_d;
         src_adv_q    <= src_adv_d;
         coeff_one_q  <= coeff_one_d;
         coeff_half_q <= coeff_half_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign done       = done_q;
   assign src_idx    = src_idx_q;
   assign x_blend    = x_blend_q;
   assign src_adv    = src_adv_q;
   assign coeff_one  = coeff_one_q;
   assign coeff_half = coeff_half_q;

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Directed scoreboard bench for bicubic_phase_gen: expected phases come from a
// 64-bit reference of pos_i = i*step and are popped on every accepted transfer.
module tb_bicubic_phase_gen;
   localparam int FRAC_W = 8;
   localparam int DIM_W  = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [DIM_W-1:0]  src_len = '0;
   logic [DIM_W-1:0]  dst_len = '0;
   logic [19:0]       step = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DIM_W-1:0]  src_idx;
   logic [FRAC_W:0]   x_blend;
   logic [4:0]        src_adv;
   logic [FRAC_W:0]   coeff_one;
   logic [FRAC_W:0]   coeff_half;
   logic              done;

   typedef struct packed {
      logic [DIM_W-1:0] idx;
      logic [FRAC_W:0]  blend;
      logic [4:0]       adv;
   } phase_t;

   phase_t exp_q[$];
   phase_t model[64];
   phase_t mon_p;
   int     n_xfer = 0;
   int     pass_cnt = 0;
   int     check_cnt = 0;

   bicubic_phase_gen #(.FRAC_W(FRAC_W), .DIM_W(DIM_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .src_len    (src_len),
      .dst_len    (dst_len),
      .step       (step),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .src_idx    (src_idx),
      .x_blend    (x_blend),
      .src_adv    (src_adv),
      .coeff_one  (coeff_one),
      .coeff_half (coeff_half),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_cnt++;
      assert (observed === expected) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   // Reference phases straight from pos_i = i*step, no running accumulator.
   task automatic buildModel(input int src, input int dst, input logic [19:0] stp);
      longint pos, ip;
      int     idx, prev;
      phase_t p;
      exp_q.delete();
      prev = 0;
      for (int i = 0; i < dst; i++) begin
         pos = longint'(i) * longint'(stp);
         ip  = pos >> 16;
         if (ip > longint'(src - 1)) begin
            idx     = src - 1;
            p.blend = '0;
         end else begin
            idx     = int'(ip);
            p.blend = 9'((pos >> 8) & 255);
         end
         p.idx = 12'(idx);
         p.adv = (i == 0) ? 5'd0 : 5'(idx - prev);
         prev  = idx;
         model[i] = p;
         exp_q.push_back(p);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         checkOutput($sformatf("sb_pending[%0d]", n_xfer), 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_p = exp_q.pop_front();
            checkOutput($sformatf("idx[%0d]", n_xfer), 32'(src_idx), 32'(mon_p.idx));
            checkOutput($sformatf("blend[%0d]", n_xfer), 32'(x_blend), 32'(mon_p.blend));
            checkOutput($sformatf("adv[%0d]", n_xfer), 32'(src_adv), 32'(mon_p.adv));
         end
         n_xfer++;
      end
   end

   task automatic applyStimulus(input int src, input int dst, input logic [19:0] stp);
      buildModel(src, dst, stp);
      n_xfer = 0;
      @(posedge clk); #1;
      src_len   = 12'(src);
      dst_len   = 12'(dst);
      step      = stp;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({pfx, "_done"}, 32'(done), 32'd0);
      checkOutput({pfx, "_idx"}, 32'(src_idx), 32'd0);
      checkOutput({pfx, "_blend"}, 32'(x_blend), 32'd0);
      checkOutput({pfx, "_adv"}, 32'(src_adv), 32'd0);
      checkOutput({pfx, "_one"}, 32'(coeff_one), 32'd0);
      checkOutput({pfx, "_half"}, 32'(coeff_half), 32'd0);
   endtask

   // Runs a whole line; optional backpressure window and an ignored mid-line start.
   task automatic runLine(input int src, input int dst, input logic [19:0] stp,
                          input int stall_at, input int stall_n, input int restart_at);
      int edges, done_at, stall_left;
      bit restarted;
      applyStimulus(src, dst, stp);
      checkOutput("first_valid", 32'(out_valid), 32'(dst != 0));
      stall_left = stall_n;
      edges      = 0;
      done_at    = -1;
      restarted  = 1'b0;
      while (done_at < 0 && edges < dst + stall_n + 10) begin
         @(negedge clk);
         if (out_valid && !out_ready && n_xfer < dst) begin
            checkOutput($sformatf("hold_idx[%0d]", n_xfer), 32'(src_idx), 32'(model[n_xfer].idx));
            checkOutput($sformatf("hold_blend[%0d]", n_xfer), 32'(x_blend), 32'(model[n_xfer].blend));
            checkOutput($sformatf("hold_adv[%0d]", n_xfer), 32'(src_adv), 32'(model[n_xfer].adv));
         end
         if (done) begin
            done_at = edges;
            checkOutput("valid_at_done", 32'(out_valid), 32'd0);
         end else begin
            @(posedge clk); #1;
            edges++;
            start = 1'b0;
            if (restart_at >= 0 && n_xfer == restart_at && !restarted) begin
               start     = 1'b1;
               src_len   = 12'd10;
               dst_len   = 12'd2;
               step      = 20'h28000;
               restarted = 1'b1;
            end
            if (stall_left > 0 && n_xfer == stall_at) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
         end
      end
      start = 1'b0;
      checkOutput("done_edge", 32'(done_at), 32'((dst == 0) ? 1 : dst + stall_n));
      @(negedge clk);
      checkOutput("done_pulse_end", 32'(done), 32'd0);
      checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Power-on reset, then coefficients appear on the first edge after release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("por");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("por_one_pre_edge", 32'(coeff_one), 32'd0);
      @(negedge clk);
      checkOutput("por_one", 32'(coeff_one), 32'd256);
      checkOutput("por_half", 32'(coeff_half), 32'd128);

      $display("[TB] upscale 2x");
      runLine(4, 8, 20'h08000, -1, 0, -1);
      $display("[TB] downscale 2.5x");
      runLine(10, 4, 20'h28000, -1, 0, -1);
      $display("[TB] clamp at right edge");
      runLine(3, 4, 20'h10000, -1, 0, -1);
      $display("[TB] backpressure at output 2");
      runLine(4, 8, 20'h08000, 2, 3, -1);
      $display("[TB] empty line");
      runLine(4, 0, 20'h08000, -1, 0, -1);
      $display("[TB] zero step");
      runLine(5, 3, 20'h00000, -1, 0, -1);
      $display("[TB] start during RUN");
      runLine(4, 8, 20'h08000, -1, 0, 3);

      $display("[TB] abort at output 3");
      applyStimulus(4, 8, 20'h08000);
      for (int k = 0; k < 20 && n_xfer < 3; k++) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_reached", 32'(n_xfer), 32'd3);
      abort     = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      abort     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("abort_valid[%0d]", k), 32'(out_valid), 32'd0);
         checkOutput($sformatf("abort_done[%0d]", k), 32'(done), 32'd0);
      end
      exp_q.delete();
      runLine(4, 8, 20'h08000, -1, 0, -1);

      $display("[TB] async reset at output 5");
      applyStimulus(4, 8, 20'h08000);
      for (int k = 0; k < 20 && n_xfer < 5; k++) begin
         @(posedge clk); #1;
      end
      checkOutput("reset_reached", 32'(n_xfer), 32'd5);
      checkOutput("reset_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("async");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rel_one_pre_edge", 32'(coeff_one), 32'd0);
      @(negedge clk);
      checkOutput("rel_one", 32'(coeff_one), 32'd256);
      checkOutput("rel_half", 32'(coeff_half), 32'd128);
      checkOutput("rel_valid", 32'(out_valid), 32'd0);
      checkOutput("rel_done", 32'(done), 32'd0);
      exp_q.delete();
      runLine(3, 4, 20'h10000, -1, 0, -1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
